// File: rtl/priv_cnt_tlb_exec_if.sv
// Bundle between the execute unit and its neighbours: decoded op in, TLB request/response, CSR strobes and GPR writeback.
interface priv_cnt_tlb_exec_if #(
    parameter int unsigned TLBIDX_W = 4
);
    logic                flush;
    logic                op_valid;
    logic                op_ready;
    logic [7:0]          op_aluop;
    logic                op_csr_read_en;
    logic [4:0]          op_rd;
    logic [31:0]         csr_tid;
    logic [TLBIDX_W-1:0] csr_tlbidx_index;
    logic                tlb_req;
    logic [1:0]          tlb_op;
    logic [TLBIDX_W-1:0] tlb_idx;
    logic                tlb_gnt;
    logic                tlb_resp_valid;
    logic                tlb_resp_hit;
    logic [TLBIDX_W-1:0] tlb_resp_idx;
    logic                csr_tlbidx_we;
    logic                csr_tlbidx_ne;
    logic [TLBIDX_W-1:0] csr_tlbidx_index_o;
    logic                csr_tlbrd_we;
    logic                wb_valid;
    logic                wb_en;
    logic [4:0]          wb_addr;
    logic [31:0]         wb_data;

    modport slave (
        input  flush, op_valid, op_aluop, op_csr_read_en, op_rd, csr_tid, csr_tlbidx_index,
        input  tlb_gnt, tlb_resp_valid, tlb_resp_hit, tlb_resp_idx,
        output op_ready, tlb_req, tlb_op, tlb_idx,
        output csr_tlbidx_we, csr_tlbidx_ne, csr_tlbidx_index_o, csr_tlbrd_we,
        output wb_valid, wb_en, wb_addr, wb_data
    );

    modport master (
        output flush, op_valid, op_aluop, op_csr_read_en, op_rd, csr_tid, csr_tlbidx_index,
        output tlb_gnt, tlb_resp_valid, tlb_resp_hit, tlb_resp_idx,
        input  op_ready, tlb_req, tlb_op, tlb_idx,
        input  csr_tlbidx_we, csr_tlbidx_ne, csr_tlbidx_index_o, csr_tlbrd_we,
        input  wb_valid, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/priv_cnt_tlb_exec.sv
// Execute unit for counter reads and TLB maintenance ops: owns the 64-bit stable counter,
// sequences one TLB op at a time, and produces CSR strobes plus the GPR writeback.
module priv_cnt_tlb_exec #(
    parameter int unsigned TLBIDX_W     = 4,
    parameter logic [7:0]  ALU_RDCNTID  = 8'h50,
    parameter logic [7:0]  ALU_RDCNTVHW = 8'h51,
    parameter logic [7:0]  ALU_TLBSRCH  = 8'h52,
    parameter logic [7:0]  ALU_TLBRD    = 8'h53,
    parameter logic [7:0]  ALU_TLBWR    = 8'h54,
    parameter logic [7:0]  ALU_TLBFILL  = 8'h55
) (
    input logic               clk,
    input logic               rst_n,
    priv_cnt_tlb_exec_if.slave bus
);
    localparam int unsigned CNT_W    = 64;
    localparam logic [1:0]  TLB_SRCH = 2'd0;
    localparam logic [1:0]  TLB_RD   = 2'd1;
    localparam logic [1:0]  TLB_WR   = 2'd2;
    localparam logic [1:0]  TLB_FILL = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_CNT, S_TLB_REQ, S_TLB_WAIT, S_DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_q;
    logic                is_hi_q;
    logic                rden_q;
    logic [4:0]          rd_q;
    logic [31:0]         tid_q;
    logic [TLBIDX_W-1:0] idx_q;
    logic                squash_q;
    logic                wb_valid_q;
    logic                tlbidx_we_q;
    logic                tlbrd_we_q;

    logic                accept_c;
    logic                is_cnt_c;
    logic                is_tlb_c;
    logic [1:0]          tlb_op_c;
    logic [TLBIDX_W-1:0] tlb_idx_c;
    logic [31:0]         cnt_res_c;

    // Decode of the offered op and the TLB index it will drive.
    always_comb begin
        accept_c  = bus.op_valid && bus.op_ready && !bus.flush;
        is_cnt_c  = (bus.op_aluop == ALU_RDCNTID) || (bus.op_aluop == ALU_RDCNTVHW);
        is_tlb_c  = 1'b1;
        tlb_op_c  = TLB_SRCH;
        tlb_idx_c = '0;
        if (bus.op_aluop == ALU_TLBSRCH)      tlb_op_c = TLB_SRCH;
        else if (bus.op_aluop == ALU_TLBRD)   tlb_op_c = TLB_RD;
        else if (bus.op_aluop == ALU_TLBWR)   tlb_op_c = TLB_WR;
        else if (bus.op_aluop == ALU_TLBFILL) tlb_op_c = TLB_FILL;
        else                                  is_tlb_c = 1'b0;
        if (tlb_op_c == TLB_RD || tlb_op_c == TLB_WR) tlb_idx_c = bus.csr_tlbidx_index;
        else if (tlb_op_c == TLB_FILL)                tlb_idx_c = cnt[TLBIDX_W-1:0];
        cnt_res_c = is_hi_q ? cnt_q[63:32] : (rden_q ? tid_q : cnt_q[31:0]);
    end

    // A flush in the completion cycle still cancels the pulses being presented.
    assign bus.wb_valid      = wb_valid_q  && !bus.flush;
    assign bus.csr_tlbidx_we = tlbidx_we_q && !bus.flush;
    assign bus.csr_tlbrd_we  = tlbrd_we_q  && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= S_IDLE;
            cnt                    <= '0;
            cnt_q                  <= '0;
            is_hi_q                <= 1'b0;
            rden_q                 <= 1'b0;
            rd_q                   <= '0;
            tid_q                  <= '0;
            idx_q                  <= '0;
            squash_q               <= 1'b0;
            wb_valid_q             <= 1'b0;
            tlbidx_we_q            <= 1'b0;
            tlbrd_we_q             <= 1'b0;
            bus.op_ready           <= 1'b1;
            bus.tlb_req            <= 1'b0;
            bus.tlb_op             <= TLB_SRCH;
            bus.tlb_idx            <= '0;
            bus.csr_tlbidx_ne      <= 1'b0;
            bus.csr_tlbidx_index_o <= '0;
            bus.wb_en              <= 1'b0;
            bus.wb_addr            <= '0;
            bus.wb_data            <= '0;
        end else begin
            cnt         <= cnt + CNT_W'(1);
            wb_valid_q  <= 1'b0;
            tlbidx_we_q <= 1'b0;
            tlbrd_we_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        cnt_q        <= cnt;
                        is_hi_q      <= (bus.op_aluop == ALU_RDCNTVHW);
                        rden_q       <= bus.op_csr_read_en;
                        rd_q         <= bus.op_rd;
                        tid_q        <= bus.csr_tid;
                        idx_q        <= bus.csr_tlbidx_index;
                        bus.op_ready <= 1'b0;
                        if (is_cnt_c) begin
                            state <= S_CNT;
                        end else if (is_tlb_c) begin
                            state       <= S_TLB_REQ;
                            bus.tlb_req <= 1'b1;
                            bus.tlb_op  <= tlb_op_c;
                            bus.tlb_idx <= tlb_idx_c;
                        end else begin
                            state       <= S_DONE;
                            wb_valid_q  <= 1'b1;
                            bus.wb_en   <= 1'b0;
                            bus.wb_addr <= '0;
                            bus.wb_data <= '0;
                        end
                    end
                end
                S_CNT: begin
                    if (bus.flush) begin
                        state        <= S_IDLE;
                        bus.op_ready <= 1'b1;
                    end else begin
                        state       <= S_DONE;
                        wb_valid_q  <= 1'b1;
                        bus.wb_en   <= 1'b1;
                        bus.wb_addr <= rd_q;
                        bus.wb_data <= cnt_res_c;
                    end
                end
                S_TLB_REQ: begin
                    // Once granted the TLB side effect happens; a coincident flush only squashes completion.
                    if (bus.tlb_gnt) begin
                        state       <= S_TLB_WAIT;
                        bus.tlb_req <= 1'b0;
                        squash_q    <= bus.flush;
                    end else if (bus.flush) begin
                        state        <= S_IDLE;
                        bus.tlb_req  <= 1'b0;
                        bus.op_ready <= 1'b1;
                    end
                end
                S_TLB_WAIT: begin
                    if (bus.tlb_resp_valid) begin
                        squash_q <= 1'b0;
                        if (squash_q || bus.flush) begin
                            state        <= S_IDLE;
                            bus.op_ready <= 1'b1;
                        end else begin
                            state       <= S_DONE;
                            wb_valid_q  <= 1'b1;
                            bus.wb_en   <= 1'b0;
                            bus.wb_addr <= '0;
                            bus.wb_data <= '0;
                            tlbrd_we_q  <= (bus.tlb_op == TLB_RD);
                            if (bus.tlb_op == TLB_SRCH) begin
                                tlbidx_we_q            <= 1'b1;
                                bus.csr_tlbidx_ne      <= !bus.tlb_resp_hit;
                                bus.csr_tlbidx_index_o <= bus.tlb_resp_hit ? bus.tlb_resp_idx : idx_q;
                            end
                        end
                    end else if (bus.flush) begin
                        squash_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    bus.op_ready <= 1'b1;
                    bus.wb_en    <= 1'b0;
                end
                default: begin
                    state        <= S_IDLE;
                    bus.op_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_priv_cnt_tlb_exec.sv
// Self-checking bench for priv_cnt_tlb_exec: random counter and TLB ops against a transaction-level model.
module tb_priv_cnt_tlb_exec;
    localparam logic [7:0] OP_RDCNTID  = 8'h50;
    localparam logic [7:0] OP_RDCNTVHW = 8'h51;
    localparam logic [7:0] OP_TLBSRCH  = 8'h52;
    localparam logic [7:0] OP_TLBRD    = 8'h53;
    localparam logic [7:0] OP_TLBWR    = 8'h54;
    localparam logic [7:0] OP_TLBFILL  = 8'h55;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] cyc   = 64'd0;
    int          n_vec = 0;
    int          n_err = 0;

    priv_cnt_tlb_exec_if #(.TLBIDX_W(4)) bus ();

    priv_cnt_tlb_exec #(
        .TLBIDX_W(4), .ALU_RDCNTID(OP_RDCNTID), .ALU_RDCNTVHW(OP_RDCNTVHW),
        .ALU_TLBSRCH(OP_TLBSRCH), .ALU_TLBRD(OP_TLBRD), .ALU_TLBWR(OP_TLBWR), .ALU_TLBFILL(OP_TLBFILL)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference stable counter: cycles elapsed since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 64'd0;
        else        cyc <= cyc + 64'd1;
    end

    function automatic logic [31:0] model_cnt(input logic [7:0] op, input logic rden,
                                              input logic [31:0] tid, input logic [63:0] c);
        if (op == OP_RDCNTVHW) return c[63:32];
        return rden ? tid : c[31:0];
    endfunction

    function automatic logic [1:0] model_tlb_code(input logic [7:0] op);
        return (op == OP_TLBSRCH) ? 2'd0 : (op == OP_TLBRD) ? 2'd1 : (op == OP_TLBWR) ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [3:0] model_tlb_idx(input logic [7:0] op, input logic [3:0] cidx,
                                                 input logic [63:0] c);
        if (op == OP_TLBSRCH) return 4'd0;
        if (op == OP_TLBFILL) return 4'(c % 64'd16);
        return cidx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic rden, input logic [4:0] rd, output logic [63:0] acc);
        bus.op_valid       = 1'b1;
        bus.op_aluop       = op;
        bus.op_csr_read_en = rden;
        bus.op_rd          = rd;
        acc                = cyc;
        tick();
        bus.op_valid       = 1'b0;
    endtask

    task automatic test_reset();
        bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op_aluop = 8'h00; bus.op_csr_read_en = 1'b0;
        bus.op_rd = 5'd0; bus.csr_tid = 32'd0; bus.csr_tlbidx_index = 4'd0; bus.tlb_gnt = 1'b0;
        bus.tlb_resp_valid = 1'b0; bus.tlb_resp_hit = 1'b0; bus.tlb_resp_idx = 4'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.op_ready, bus.tlb_req, bus.tlb_op, bus.tlb_idx, bus.wb_valid, bus.wb_en} !== 10'b10_0000_0000) begin
            n_err++; $display("FAIL reset_ctl: got rdy=%b req=%b op=%0d idx=%0d wbv=%b wbe=%b required 1,0,0,0,0,0",
                              bus.op_ready, bus.tlb_req, bus.tlb_op, bus.tlb_idx, bus.wb_valid, bus.wb_en);
        end
        n_vec++;
        if ({bus.wb_addr, bus.wb_data, bus.csr_tlbidx_we, bus.csr_tlbidx_ne, bus.csr_tlbidx_index_o, bus.csr_tlbrd_we} !== 44'd0) begin
            n_err++; $display("FAIL reset_data: got addr=%0d data=%h tidx_we=%b ne=%b idx=%0d rd_we=%b required all 0",
                              bus.wb_addr, bus.wb_data, bus.csr_tlbidx_we, bus.csr_tlbidx_ne, bus.csr_tlbidx_index_o, bus.csr_tlbrd_we);
        end
        tick();
    endtask

    task automatic test_counter();
        logic [63:0] acc;
        logic [31:0] exp, tid;
        logic [7:0]  op;
        logic        rden;
        logic [4:0]  rd;
        repeat (10) tick();
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      begin op = OP_RDCNTVHW; rden = 1'b0; rd = 5'd5; end
            else if (i == 1) begin op = OP_RDCNTID;  rden = 1'b0; rd = 5'd5; end
            else if (i == 2) begin op = OP_RDCNTID;  rden = 1'b1; rd = 5'd7; bus.csr_tid = 32'hDEAD_0001; end
            else begin
                op   = ($urandom_range(0, 1) == 0) ? OP_RDCNTID : OP_RDCNTVHW;
                rden = 1'($urandom_range(0, 1));
                rd   = 5'($urandom);
                bus.csr_tid = $urandom;
                repeat ($urandom_range(0, 3)) tick();
            end
            tid = bus.csr_tid;
            issue(op, rden, rd, acc);
            exp = model_cnt(op, rden, tid, acc);
            bus.csr_tid = $urandom;
            @(negedge clk);
            n_vec++;
            if (bus.wb_valid !== 1'b0) begin
                n_err++; $display("FAIL cnt_early[%0d]: wb_valid=%b at accept+1, required 0", i, bus.wb_valid);
            end
            tick();
            @(negedge clk);
            n_vec++;
            if ({bus.wb_valid, bus.wb_en, bus.op_ready, bus.wb_addr} !== {3'b110, rd}) begin
                n_err++; $display("FAIL cnt_ctl[%0d]: got v=%b en=%b rdy=%b addr=%0d required 1,1,0,%0d",
                                  i, bus.wb_valid, bus.wb_en, bus.op_ready, bus.wb_addr, rd);
            end
            n_vec++;
            if (bus.wb_data !== exp) begin
                n_err++; $display("FAIL cnt_data[%0d]: got %h required %h", i, bus.wb_data, exp);
            end
            tick();
            @(negedge clk);
            n_vec++;
            if ({bus.wb_valid, bus.op_ready} !== 2'b01) begin
                n_err++; $display("FAIL cnt_after[%0d]: got v=%b rdy=%b required 0,1", i, bus.wb_valid, bus.op_ready);
            end
        end
        tick();
    endtask

    task automatic test_unknown();
        logic [63:0] acc;
        logic [7:0]  op;
        for (int i = 0; i < 3; i++) begin
            op = 8'($urandom);
            while (op inside {OP_RDCNTID, OP_RDCNTVHW, OP_TLBSRCH, OP_TLBRD, OP_TLBWR, OP_TLBFILL}) op = op + 8'd7;
            issue(op, 1'b1, 5'($urandom), acc);
            @(negedge clk);
            n_vec++;
            if ({bus.wb_valid, bus.wb_en, bus.op_ready, bus.tlb_req} !== 4'b1000) begin
                n_err++; $display("FAIL unknown[%0d]: op=%h got v=%b en=%b rdy=%b req=%b required 1,0,0,0",
                                  i, op, bus.wb_valid, bus.wb_en, bus.op_ready, bus.tlb_req);
            end
            tick();
            @(negedge clk);
            n_vec++;
            if ({bus.wb_valid, bus.op_ready} !== 2'b01) begin
                n_err++; $display("FAIL unknown_after[%0d]: got v=%b rdy=%b required 0,1", i, bus.wb_valid, bus.op_ready);
            end
            tick();
        end
    endtask

    task automatic test_tlb();
        logic [63:0] acc;
        logic [7:0]  op;
        logic [3:0]  cidx, ridx, e_idx, e_index;
        logic [1:0]  e_op;
        logic        hit, e_srch, e_rd;
        int          gd, rdl;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0: begin op = OP_TLBSRCH; cidx = 4'd5; gd = 3; rdl = 1; hit = 1'b1; ridx = 4'd9; end
                1: begin op = OP_TLBSRCH; cidx = 4'd6; gd = 0; rdl = 2; hit = 1'b0; ridx = 4'd2; end
                2: begin op = OP_TLBRD;   cidx = 4'd3; gd = 1; rdl = 0; hit = 1'b0; ridx = 4'd0; end
                3: begin op = OP_TLBWR;   cidx = 4'd3; gd = 2; rdl = 1; hit = 1'b1; ridx = 4'd1; end
                4: begin op = OP_TLBFILL; cidx = 4'd3; gd = 0; rdl = 0; hit = 1'b0; ridx = 4'd0; end
                default: begin
                    op   = OP_TLBSRCH + 8'($urandom_range(0, 3));
                    cidx = 4'($urandom); gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
                    hit  = 1'($urandom_range(0, 1)); ridx = 4'($urandom);
                end
            endcase
            if (i == 4) for (int k = 0; k < 16 && cyc[3:0] != 4'hA; k++) tick();
            bus.csr_tlbidx_index = cidx;
            issue(op, 1'b0, 5'($urandom), acc);
            bus.csr_tlbidx_index = 4'($urandom);
            e_op    = model_tlb_code(op);
            e_idx   = model_tlb_idx(op, cidx, acc);
            e_srch  = (op == OP_TLBSRCH);
            e_rd    = (op == OP_TLBRD);
            e_index = hit ? ridx : cidx;
            for (int d = 0; d <= gd; d++) begin
                if (d == gd) bus.tlb_gnt = 1'b1;
                @(negedge clk);
                n_vec++;
                if ({bus.tlb_req, bus.tlb_op, bus.tlb_idx} !== {1'b1, e_op, e_idx}) begin
                    n_err++; $display("FAIL tlb_req[%0d.%0d]: got req=%b op=%0d idx=%h required 1,%0d,%h",
                                      i, d, bus.tlb_req, bus.tlb_op, bus.tlb_idx, e_op, e_idx);
                end
                tick();
            end
            bus.tlb_gnt = 1'b0;
            for (int d = 0; d <= rdl; d++) begin
                if (d == rdl) begin
                    bus.tlb_resp_valid = 1'b1; bus.tlb_resp_hit = hit; bus.tlb_resp_idx = ridx;
                end
                @(negedge clk);
                n_vec++;
                if ({bus.tlb_req, bus.wb_valid, bus.csr_tlbidx_we, bus.csr_tlbrd_we, bus.op_ready} !== 5'b0) begin
                    n_err++; $display("FAIL tlb_wait[%0d.%0d]: got req=%b v=%b tidx_we=%b rd_we=%b rdy=%b required all 0",
                                      i, d, bus.tlb_req, bus.wb_valid, bus.csr_tlbidx_we, bus.csr_tlbrd_we, bus.op_ready);
                end
                tick();
            end
            bus.tlb_resp_valid = 1'b0; bus.tlb_resp_hit = 1'($urandom); bus.tlb_resp_idx = 4'($urandom);
            @(negedge clk);
            n_vec++;
            if ({bus.wb_valid, bus.wb_en, bus.op_ready, bus.csr_tlbidx_we, bus.csr_tlbrd_we} !== {3'b100, e_srch, e_rd}) begin
                n_err++; $display("FAIL tlb_done[%0d]: got v=%b en=%b rdy=%b tidx_we=%b rd_we=%b required 1,0,0,%b,%b",
                                  i, bus.wb_valid, bus.wb_en, bus.op_ready, bus.csr_tlbidx_we, bus.csr_tlbrd_we, e_srch, e_rd);
            end
            if (e_srch) begin
                n_vec++;
                if ({bus.csr_tlbidx_ne, bus.csr_tlbidx_index_o} !== {!hit, e_index}) begin
                    n_err++; $display("FAIL tlb_srch[%0d]: got ne=%b idx=%h required %b,%h",
                                      i, bus.csr_tlbidx_ne, bus.csr_tlbidx_index_o, !hit, e_index);
                end
            end
            tick();
            @(negedge clk);
            n_vec++;
            if ({bus.wb_valid, bus.csr_tlbidx_we, bus.csr_tlbrd_we, bus.op_ready} !== 4'b0001) begin
                n_err++; $display("FAIL tlb_after[%0d]: got v=%b tidx_we=%b rd_we=%b rdy=%b required 0,0,0,1",
                                  i, bus.wb_valid, bus.csr_tlbidx_we, bus.csr_tlbrd_we, bus.op_ready);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [63:0] acc;
        logic        bad;
        // Flush in the accept cycle blocks acceptance.
        bus.op_valid = 1'b1; bus.op_aluop = OP_RDCNTID; bus.flush = 1'b1;
        tick();
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.wb_valid !== 1'b0 || bus.op_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        n_vec++;
        if (bad !== 1'b0) begin n_err++; $display("FAIL flush_accept: op accepted under flush, got 1 required 0"); end
        // Flush in CNT.
        issue(OP_RDCNTID, 1'b0, 5'd3, acc);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.wb_valid !== 1'b0 || bus.op_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        n_vec++;
        if (bad !== 1'b0) begin n_err++; $display("FAIL flush_cnt: completion or busy after flush, got 1 required 0"); end
        // Flush in DONE.
        issue(OP_RDCNTVHW, 1'b0, 5'd4, acc);
        tick();
        bus.flush = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_done: wb_valid=%b required 0", bus.wb_valid); end
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL flush_done_rdy: op_ready=%b required 1", bus.op_ready); end
        tick();
        // Flush in TLB_REQ before grant.
        issue(OP_TLBWR, 1'b0, 5'd1, acc);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.tlb_req, bus.op_ready} !== 2'b01) begin
            n_err++; $display("FAIL flush_req: got req=%b rdy=%b required 0,1", bus.tlb_req, bus.op_ready);
        end
        tick();
        // Flush in TLB_WAIT: response absorbed silently.
        bus.csr_tlbidx_index = 4'd2;
        issue(OP_TLBSRCH, 1'b0, 5'd1, acc);
        bus.tlb_gnt = 1'b1;
        tick();
        bus.tlb_gnt = 1'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.tlb_resp_valid = 1'b1; bus.tlb_resp_hit = 1'b1; bus.tlb_resp_idx = 4'd9;
        @(negedge clk);
        n_vec++;
        if (bus.op_ready !== 1'b0) begin n_err++; $display("FAIL flush_wait_busy: op_ready=%b required 0", bus.op_ready); end
        tick();
        bus.tlb_resp_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.wb_valid, bus.csr_tlbidx_we, bus.op_ready} !== 3'b001) begin
            n_err++; $display("FAIL flush_wait: got v=%b tidx_we=%b rdy=%b required 0,0,1", bus.wb_valid, bus.csr_tlbidx_we, bus.op_ready);
        end
        tick();
        // Flush coincident with grant.
        issue(OP_TLBRD, 1'b0, 5'd1, acc);
        bus.tlb_gnt = 1'b1; bus.flush = 1'b1;
        tick();
        bus.tlb_gnt = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.tlb_req, bus.op_ready} !== 2'b00) begin
            n_err++; $display("FAIL flush_gnt_busy: got req=%b rdy=%b required 0,0", bus.tlb_req, bus.op_ready);
        end
        tick();
        bus.tlb_resp_valid = 1'b1;
        tick();
        bus.tlb_resp_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.wb_valid, bus.csr_tlbrd_we, bus.op_ready} !== 3'b001) begin
            n_err++; $display("FAIL flush_gnt: got v=%b rd_we=%b rdy=%b required 0,0,1", bus.wb_valid, bus.csr_tlbrd_we, bus.op_ready);
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [63:0] acc;
        logic        bad;
        for (int i = 0; i < 2; i++) begin
            issue((i == 0) ? OP_TLBSRCH : OP_TLBRD, 1'b0, 5'd2, acc);
            if (i == 1) begin
                bus.tlb_gnt = 1'b1;
                tick();
                bus.tlb_gnt = 1'b0;
            end
            @(negedge clk);
            n_vec++;
            if ({bus.tlb_req, bus.op_ready} !== {(i == 0), 1'b0}) begin
                n_err++; $display("FAIL arst_pre[%0d]: got req=%b rdy=%b required %b,0", i, bus.tlb_req, bus.op_ready, i == 0);
            end
            #2 rst_n = 1'b0;
            #1;
            n_vec++;
            if ({bus.tlb_req, bus.op_ready, bus.wb_valid} !== 3'b010) begin
                n_err++; $display("FAIL arst_now[%0d]: got req=%b rdy=%b v=%b required 0,1,0", i, bus.tlb_req, bus.op_ready, bus.wb_valid);
            end
            tick();
            rst_n = 1'b1;
            bus.tlb_resp_valid = 1'b1; bus.tlb_resp_hit = 1'b1;
            tick();
            bus.tlb_resp_valid = 1'b0;
            bad = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if ({bus.wb_valid, bus.csr_tlbidx_we, bus.csr_tlbrd_we, bus.tlb_req, bus.op_ready} !== 5'b00001) bad = 1'b1;
                tick();
            end
            n_vec++;
            if (bad !== 1'b0) begin n_err++; $display("FAIL arst_stray[%0d]: stray response produced activity, got 1 required 0", i); end
        end
        // Counter restarted from zero at reset release.
        issue(OP_RDCNTID, 1'b0, 5'd9, acc);
        tick();
        @(negedge clk);
        n_vec++;
        if ({bus.wb_valid, bus.wb_data} !== {1'b1, acc[31:0]}) begin
            n_err++; $display("FAIL arst_cnt: got v=%b data=%h required 1,%h", bus.wb_valid, bus.wb_data, acc[31:0]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_counter();
        test_unknown();
        test_tlb();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
